mem_req_scheduler: RTL and testbench

- Sequences instruction-fetch and data-access requests from the single-cycle core onto one shared RAM port, one transaction at a time.
- Data requests have priority. An anti-starvation counter forces an instruction grant after a configurable number of consecutive data grants.
- Latches the granted address and store data, holds the RAM strobes until the RAM drops busy, then returns a one-cycle ready pulse with registered load data.
- A watchdog aborts transactions on which the RAM stays busy too long.

---
 rtl/mem_req_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_mem_req_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_scheduler.sv
// Shares one RAM port between instruction-fetch and data-access requesters.
// Data has priority; an anti-starvation counter and a busy watchdog bound latency.
module mem_req_scheduler #(
    parameter int unsigned STARVE_LIMIT   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemRen,
    input  logic [31:0] imemaddr,
    input  logic        dmmRen,
    input  logic        dmmWen,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    input  logic        busy_o,
    input  logic [31:0] ramload,
    output logic        Ren,
    output logic        Wen,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        i_ready,
    output logic        d_ready,
    output logic [31:0] imemload,
    output logic [31:0] dmmload,
    output logic        i_wait,
    output logic        d_wait,
    output logic        bus_err
);

    localparam logic [3:0] StarveLimit   = 4'(STARVE_LIMIT);
    localparam logic [7:0] TimeoutCycles = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [31:0] ramaddr_q, ramaddr_d;
    logic [31:0] ramstore_q, ramstore_d;
    logic        own_d_q, own_d_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] imemload_q, imemload_d;
    logic [31:0] dmmload_q, dmmload_d;

    logic        d_req;
    logic        grant_i;
    logic [7:0]  tmo_inc;

    assign d_req   = dmmRen | dmmWen;
    assign tmo_inc = tmo_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        ren_d        = ren_q;
        wen_d        = wen_q;
        ramaddr_d    = ramaddr_q;
        ramstore_d   = ramstore_q;
        own_d_d      = own_d_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        bus_err_d    = 1'b0;
        imemload_d   = imemload_q;
        dmmload_d    = dmmload_q;
        grant_i      = 1'b0;

        unique case (state_q)
            StIdle: begin
                ren_d = 1'b0;
                wen_d = 1'b0;
                if (d_req || imemRen) begin
                    // Instruction wins only when alone or when data has hit the starve limit.
                    grant_i = imemRen &&
                              (!d_req || (StarveLimit != 4'd0 && starve_cnt_q == StarveLimit));
                    if (grant_i) begin
                        own_d_d      = 1'b0;
                        ramaddr_d    = imemaddr;
                        ren_d        = 1'b1;
                        starve_cnt_d = 4'd0;
                    end else begin
                        own_d_d    = 1'b1;
                        ramaddr_d  = dmmaddr;
                        ramstore_d = dmmstore;
                        wen_d      = dmmWen;
                        ren_d      = ~dmmWen;
                        if (imemRen && starve_cnt_q != StarveLimit) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end
                    tmo_cnt_d = 8'd0;
                    state_d   = StIssue;
                end
            end

            StIssue: begin
                if (!busy_o) begin
                    state_d   = StResp;
                    ren_d     = 1'b0;
                    wen_d     = 1'b0;
                    i_ready_d = ~own_d_q;
                    d_ready_d = own_d_q;
                    if (!own_d_q) begin
                        imemload_d = ramload;
                    end else if (!wen_q) begin
                        dmmload_d = ramload;
                    end
                end else begin
                    tmo_cnt_d = tmo_inc;
                    if (TimeoutCycles != 8'd0 && tmo_inc == TimeoutCycles) begin
                        state_d   = StResp;
                        ren_d     = 1'b0;
                        wen_d     = 1'b0;
                        i_ready_d = ~own_d_q;
                        d_ready_d = own_d_q;
                        bus_err_d = 1'b1;
                        if (own_d_q) begin
                            dmmload_d = 32'd0;
                        end else begin
                            imemload_d = 32'd0;
                        end
                    end
                end
            end

            StResp: begin
                ren_d     = 1'b0;
                wen_d     = 1'b0;
                tmo_cnt_d = 8'd0;
                state_d   = StIdle;
            end

            default: begin
                ren_d   = 1'b0;
                wen_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            starve_cnt_q <= 4'd0;
            tmo_cnt_q    <= 8'd0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            ramaddr_q    <= 32'd0;
            ramstore_q   <= 32'd0;
            own_d_q      <= 1'b0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            imemload_q   <= 32'd0;
            dmmload_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            ren_q        <= ren_d;
            wen_q        <= wen_d;
            ramaddr_q    <= ramaddr_d;
            ramstore_q   <= ramstore_d;
            own_d_q      <= own_d_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            bus_err_q    <= bus_err_d;
            imemload_q   <= imemload_d;
            dmmload_q    <= dmmload_d;
        end
    end

    assign Ren      = ren_q;
    assign Wen      = wen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign i_ready  = i_ready_q;
    assign d_ready  = d_ready_q;
    assign bus_err  = bus_err_q;
    assign imemload = imemload_q;
    assign dmmload  = dmmload_q;
    assign i_wait   = imemRen & ~i_ready_q;
    assign d_wait   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Randomized scoreboard bench for mem_req_scheduler: a transaction-level model predicts
// each grant and its completion; a negedge monitor checks strobes and ready pulses.
module tb_mem_req_scheduler;

    localparam int unsigned StarveLimit   = 3;
    localparam int unsigned TimeoutCycles = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemRen = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        dmmRen = 1'b0;
    logic        dmmWen = 1'b0;
    logic [31:0] dmmaddr = '0;
    logic [31:0] dmmstore = '0;
    logic        busy_o = 1'b0;
    logic [31:0] ramload = '0;
    logic        Ren, Wen, i_ready, d_ready, i_wait, d_wait, bus_err;
    logic [31:0] ramaddr, ramstore, imemload, dmmload;

    mem_req_scheduler #(
        .STARVE_LIMIT  (StarveLimit),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .imemRen (imemRen),
        .imemaddr(imemaddr),
        .dmmRen  (dmmRen),
        .dmmWen  (dmmWen),
        .dmmaddr (dmmaddr),
        .dmmstore(dmmstore),
        .busy_o  (busy_o),
        .ramload (ramload),
        .Ren     (Ren),
        .Wen     (Wen),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .i_ready (i_ready),
        .d_ready (d_ready),
        .imemload(imemload),
        .dmmload (dmmload),
        .i_wait  (i_wait),
        .d_wait  (d_wait),
        .bus_err (bus_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          own_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] store;
        bit          err;
        int          issue_cycles;
        logic [31:0] iload;
        logic [31:0] dload;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int          starve = 0;
    logic [31:0] m_iload = '0;
    logic [31:0] m_dload = '0;

    // Requester state
    bit          i_pend = 0, d_pend = 0, d_rd = 0, d_wr = 0;
    logic [31:0] i_addr = '0, d_addr = '0, d_store = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply();
        imemRen  = i_pend;
        imemaddr = i_addr;
        dmmRen   = d_pend && d_rd;
        dmmWen   = d_pend && d_wr;
        dmmaddr  = d_addr;
        dmmstore = d_store;
    endtask

    task automatic set_i(input logic [31:0] a);
        i_pend = 1;
        i_addr = a;
    endtask

    task automatic set_d(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] s);
        d_pend  = 1;
        d_rd    = rd;
        d_wr    = wr;
        d_addr  = a;
        d_store = s;
    endtask

    task automatic new_reqs(input bit force_both);
        int t;
        if (!i_pend && (force_both || $urandom_range(0, 1) == 1)) set_i($urandom);
        if (!d_pend && (force_both || $urandom_range(0, 1) == 1)) begin
            t = int'($urandom_range(0, 3));
            set_d(t != 2, t >= 2, $urandom, $urandom);
        end
        if (!i_pend && !d_pend) set_i($urandom);
        apply();
    endtask

    // Predicts the next grant from the current requests, then runs the RAM side until done.
    task automatic do_txn(input int b_force, input logic [31:0] rd_force);
        exp_t        e;
        bit          gi;
        int          b;
        int          seen;
        bit          done;
        logic [31:0] rdata;
        b     = (b_force < 0) ? int'($urandom_range(0, 5)) : b_force;
        rdata = (b_force < 0) ? $urandom : rd_force;
        gi    = i_pend && (!d_pend || (StarveLimit != 0 && starve == int'(StarveLimit)));
        e.own_d = !gi;
        e.store = d_store;
        if (gi) begin
            starve = 0;
            e.addr = i_addr;
            e.wr   = 0;
        end else begin
            if (i_pend && starve < int'(StarveLimit)) starve++;
            e.addr = d_addr;
            e.wr   = d_wr;
        end
        e.err          = (TimeoutCycles != 0) && (b >= int'(TimeoutCycles));
        e.issue_cycles = e.err ? int'(TimeoutCycles) : b + 1;
        if (gi) m_iload = e.err ? 32'd0 : rdata;
        else if (e.err) m_dload = 32'd0;
        else if (!e.wr) m_dload = rdata;
        e.iload = m_iload;
        e.dload = m_dload;
        exp_q.push_back(e);

        seen = 0;
        done = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (Ren || Wen) begin
                busy_o  = (seen < b);
                ramload = (seen < b) ? $urandom : rdata;
                seen++;
                if (seen == 1 && b_force < 0 && $urandom_range(0, 3) == 0) begin
                    if (gi) i_pend = 0;
                    else d_pend = 0;
                    apply();
                end
            end else begin
                busy_o  = 1'($urandom_range(0, 1));
                ramload = $urandom;
            end
            tick();
            if (gi ? i_ready : d_ready) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL txn_complete actual=no_ready required=%s_ready", gi ? "i" : "d");
        end
        if (gi) i_pend = 0;
        else d_pend = 0;
        apply();
    endtask

    // Monitor: strobes and ready pulses against the scoreboard front.
    int run_len = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            run_len = 0;
        end else begin
            if (Ren || Wen) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    chk("strobe_unexpected", {30'd0, Ren, Wen}, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("ren", 32'(Ren), 32'(!e.wr));
                    chk("wen", 32'(Wen), 32'(e.wr));
                    chk("ramaddr", ramaddr, e.addr);
                    if (e.wr) chk("ramstore", ramstore, e.store);
                end
            end
            if (i_ready || d_ready) begin
                if (exp_q.size() == 0) begin
                    chk("ready_unexpected", {30'd0, i_ready, d_ready}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("i_ready", 32'(i_ready), 32'(!e.own_d));
                    chk("d_ready", 32'(d_ready), 32'(e.own_d));
                    chk("bus_err", 32'(bus_err), 32'(e.err));
                    chk("imemload", imemload, e.iload);
                    chk("dmmload", dmmload, e.dload);
                    chk("issue_cycles", 32'(run_len), 32'(e.issue_cycles));
                    chk("strobes_in_resp", {30'd0, Ren, Wen}, 32'd0);
                end
                run_len = 0;
            end else begin
                chk("bus_err_idle", 32'(bus_err), 32'd0);
            end
            chk("i_wait", 32'(i_wait), 32'(imemRen && !i_ready));
            chk("d_wait", 32'(d_wait), 32'((dmmRen || dmmWen) && !d_ready));
        end
    end

    initial begin
        exp_t e;
        int   n;
        // Reset with a pending instruction request
        set_i(32'h11119999);
        apply();
        busy_o  = 1'b0;
        ramload = 32'h99991111;
        RST     = 1'b1;
        tick();
        tick();
        @(negedge CLK);
        chk("rst_outputs", {Ren, Wen, i_ready, d_ready, bus_err}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_dmmload", dmmload, 32'd0);
        tick();
        RST = 1'b0;
        do_txn(0, 32'h99991111);

        // Directed data write with three busy cycles
        set_d(0, 1, 32'hABCD1234, 32'h9876DCBA);
        apply();
        do_txn(3, 32'h0);

        // Contention: both requesters always pending
        for (int k = 0; k < 16; k++) begin
            new_reqs(1);
            do_txn(-1, 32'h0);
        end
        for (int k = 0; k < 8; k++) begin
            new_reqs(1);
            do_txn(0, $urandom);
        end

        // Directed timeout on a data read
        i_pend = 0;
        set_d(1, 0, 32'h00C0FFEE, 32'h0);
        apply();
        do_txn(int'(TimeoutCycles) + 1, 32'h0);

        // Random mix
        for (int k = 0; k < 60; k++) begin
            new_reqs(0);
            do_txn(-1, 32'h0);
        end

        // Reset in the middle of an ISSUE with busy held high
        i_pend = 0;
        set_d(1, 0, 32'h5A5A0000, 32'h0);
        apply();
        e.own_d = 1; e.wr = 0; e.addr = 32'h5A5A0000; e.store = '0; e.err = 0;
        e.issue_cycles = 0; e.iload = m_iload; e.dload = m_dload;
        exp_q.push_back(e);
        busy_o = 1'b1;
        n = 0;
        while (!Ren && n < 10) begin
            tick();
            n++;
        end
        chk("midrst_ren_seen", 32'(Ren), 32'd1);
        tick();
        d_pend = 0;
        apply();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_q.delete();
        starve  = 0;
        m_iload = '0;
        m_dload = '0;
        @(negedge CLK);
        chk("midrst_ren_low", {30'd0, Ren, Wen}, 32'd0);
        chk("midrst_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            new_reqs(0);
            do_txn(-1, 32'h0);
        end
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
